mips_muldiv_unit: RTL and testbench

MIPS_MULDIV_UNIT -- requirements
Module: mips_muldiv_unit

---
 rtl/mips_muldiv_unit.sv | 170 +++++++++++++++++
 tb/tb_mips_muldiv_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS HI/LO multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Define MULDIV_SIGNED_EN to enable signed MULT/DIV (op[0]); otherwise all operations are unsigned.
module mips_muldiv_unit #(
  parameter int NBits = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [NBits-1:0] operand_a,
  input  logic [NBits-1:0] operand_b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [NBits-1:0] write_data,
  output logic             busy,
  output logic             done,
  output logic [NBits-1:0] hi,
  output logic [NBits-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(NBits) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic [NBits-1:0] rem_q, rem_d, quo_q, quo_d, dsr_q, dsr_d;
  logic [NBits-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             dbz_q, dbz_d;
  logic             accept;
  logic [NBits-1:0] a_in, b_in, rem_nx, quo_nx, res_hi, res_lo;
  logic [NBits:0]   mul_sum, div_shift, div_diff;

`ifdef MULDIV_SIGNED_EN
  logic               neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
  logic               a_neg, b_neg;
  logic [2*NBits-1:0] prod_mag;

  assign a_neg    = op[0] & operand_a[NBits-1];
  assign b_neg    = op[0] & operand_b[NBits-1];
  assign a_in     = a_neg ? -operand_a : operand_a;
  assign b_in     = b_neg ? -operand_b : operand_b;
  assign prod_mag = {rem_nx, quo_nx};

  // Iterations run on magnitudes; the sign is applied only to the final result.
  always_comb begin
    if (is_div_q) begin
      res_lo = neg_lo_q ? -quo_nx : quo_nx;
      res_hi = neg_hi_q ? -rem_nx : rem_nx;
    end else begin
      {res_hi, res_lo} = neg_lo_q ? -prod_mag : prod_mag;
    end
  end
`else
  logic unused_op0;

  assign unused_op0 = op[0];
  assign a_in       = operand_a;
  assign b_in       = operand_b;
  assign res_hi     = rem_nx;
  assign res_lo     = quo_nx;
`endif

  // One iteration: multiply shifts {rem,quo} right, divide shifts it left.
  always_comb begin
    mul_sum   = {1'b0, rem_q} + (quo_q[0] ? {1'b0, dsr_q} : '0);
    div_shift = {rem_q, quo_q[NBits-1]};
    div_diff  = div_shift - {1'b0, dsr_q};
    if (is_div_q) begin
      quo_nx = {quo_q[NBits-2:0], ~div_diff[NBits]};
      rem_nx = div_diff[NBits] ? div_shift[NBits-1:0] : div_diff[NBits-1:0];
    end else begin
      rem_nx = mul_sum[NBits:1];
      quo_nx = {mul_sum[0], quo_q[NBits-1:1]};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dsr_d    = dsr_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;
`ifdef MULDIV_SIGNED_EN
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
`endif
    accept   = start && (state_q != RUN);
    case (state_q)
      RUN: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(NBits - 1)) begin
          state_d = DONE;
          if (is_div_q && (dsr_q == '0)) begin
            dbz_d = 1'b1;
          end else begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
        end
      end
      default: begin
        if (state_q == DONE) state_d = IDLE;
        if (accept) begin
          state_d  = RUN;
          cnt_d    = '0;
          dbz_d    = 1'b0;
          is_div_d = op[1];
          rem_d    = '0;
          quo_d    = a_in;
          dsr_d    = b_in;
`ifdef MULDIV_SIGNED_EN
          neg_lo_d = a_neg ^ b_neg;
          neg_hi_d = a_neg;
`endif
        end else begin
          if (mthi) hi_d = write_data;
          if (mtlo) lo_d = write_data;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      dsr_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dsr_q    <= dsr_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
`ifdef MULDIV_SIGNED_EN
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
`endif
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed scoreboard bench for mips_muldiv_unit (NBits=32); signed expectations follow MULDIV_SIGNED_EN.
module tb_mips_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, start, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] operand_a, operand_b, write_data;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int          checks = 0;
  int          errors = 0;
  int          edges  = 0;
  int          busy_cnt = 0;
  logic [31:0] m_hi, m_lo;
  logic [31:0] ra, rb;
  logic [63:0] rp;
  logic        seen_done;
`ifdef MULDIV_SIGNED_EN
  longint      sp;
  int          sq, sr;
`endif

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t sb[$];

  mips_muldiv_unit #(.NBits(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .mthi       (mthi),
    .mtlo       (mtlo),
    .write_data (write_data),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edges++;
    if (busy === 1'b1) busy_cnt++;
  endtask

  task automatic start_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input logic ed);
    exp_t e;
    e.tag = tag;
    e.hi  = eh;
    e.lo  = el;
    e.dbz = ed;
    sb.push_back(e);
    op = o;
    operand_a = a;
    operand_b = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    edges = 0;
    busy_cnt = (busy === 1'b1) ? 1 : 0;
  endtask

  task automatic finish_op();
    exp_t e;
    while (done !== 1'b1 && edges < 100) tick();
    chkb("done_seen", done, 1'b1);
    chkb("sb_nonempty", sb.size() > 0, 1'b1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("%s_latency", e.tag), 32'(edges), 32'd32);
      chk($sformatf("%s_busy_cycles", e.tag), 32'(busy_cnt), 32'd32);
      chk($sformatf("%s_hi", e.tag), hi, e.hi);
      chk($sformatf("%s_lo", e.tag), lo, e.lo);
      chkb($sformatf("%s_dbz", e.tag), div_by_zero, e.dbz);
      m_hi = e.hi;
      m_lo = e.lo;
    end
  endtask

  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                       input logic ed);
    start_op(tag, o, a, b, eh, el, ed);
    finish_op();
    tick();
    chkb($sformatf("%s_done_pulse", tag), done, 1'b0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'b00; operand_a = '0; operand_b = '0; write_data = '0;
    repeat (2) tick();
    reset = 1'b0;
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chkb("reset_busy", busy, 1'b0);
    chkb("reset_done", done, 1'b0);
    chkb("reset_dbz", div_by_zero, 1'b0);
    m_hi = '0;
    m_lo = '0;

    do_op("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
`ifdef MULDIV_SIGNED_EN
    do_op("mult_m3x5", 2'b01, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    do_op("div_m7d2", 2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    do_op("div_min_m1", 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);
    do_op("div_7dm2", 2'b11, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0);
`else
    do_op("mult_m3x5", 2'b01, 32'hFFFFFFFD, 32'd5, 32'h00000004, 32'hFFFFFFF1, 1'b0);
    do_op("div_m7d2", 2'b11, 32'hFFFFFFF9, 32'd2, 32'd1, 32'h7FFFFFFC, 1'b0);
    do_op("div_min_m1", 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 1'b0);
    do_op("div_7dm2", 2'b11, 32'd7, 32'hFFFFFFFE, 32'd7, 32'd0, 1'b0);
`endif

    write_data = 32'h12345678;
    mthi = 1'b1;
    tick();
    mthi = 1'b0;
    chk("mthi_idle", hi, 32'h12345678);
    m_hi = 32'h12345678;
    do_op("divu_by0", 2'b10, 32'd100, 32'd0, m_hi, m_lo, 1'b1);
    repeat (2) tick();
    chkb("dbz_sticky", div_by_zero, 1'b1);

    start_op("divu_ign", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    chkb("dbz_cleared", div_by_zero, 1'b0);
    repeat (3) tick();
    op = 2'b00; operand_a = 32'd50; operand_b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    write_data = 32'hDEADBEEF;
    mtlo = 1'b1;
    tick();
    mtlo = 1'b0;
    finish_op();

    start_op("b2b", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);
    chkb("b2b_busy", busy, 1'b1);
    chkb("b2b_done_low", done, 1'b0);
    finish_op();
    tick();
    chkb("b2b_idle_busy", busy, 1'b0);

    write_data = 32'hA5A5A5A5;
    mthi = 1'b1;
    mtlo = 1'b1;
    tick();
    mthi = 1'b0;
    mtlo = 1'b0;
    chk("both_hi", hi, 32'hA5A5A5A5);
    chk("both_lo", lo, 32'hA5A5A5A5);

    write_data = 32'h11111111;
    mthi = 1'b1;
    start_op("start_wins", 2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);
    mthi = 1'b0;
    chk("start_wins_hi_held", hi, 32'hA5A5A5A5);
    finish_op();
    tick();

    op = 2'b00; operand_a = 32'h00012345; operand_b = 32'h00006789; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_run_hi", hi, 32'h0);
    chk("rst_run_lo", lo, 32'h0);
    chkb("rst_run_busy", busy, 1'b0);
    seen_done = done;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1) seen_done = 1'b1;
    end
    chkb("rst_run_no_done", seen_done, 1'b0);

    reset = 1'b1; start = 1'b1; mthi = 1'b1; mtlo = 1'b1; write_data = 32'hFFFF0000;
    tick();
    reset = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    chkb("rst_prio_busy", busy, 1'b0);
    chk("rst_prio_hi", hi, 32'h0);
    chk("rst_prio_lo", lo, 32'h0);
    m_hi = '0;
    m_lo = '0;

    do_op("after_rst", 2'b00, 32'h00010000, 32'h00010000, 32'd1, 32'd0, 1'b0);

    for (int i = 0; i < 3; i++) begin
      ra = $urandom;
      rb = $urandom;
      rp = {32'h0, ra} * {32'h0, rb};
      do_op($sformatf("multu_rnd%0d", i), 2'b00, ra, rb, rp[63:32], rp[31:0], 1'b0);
      rb = $urandom_range(1, 100000);
      do_op($sformatf("divu_rnd%0d", i), 2'b10, ra, rb, ra % rb, ra / rb, 1'b0);
`ifdef MULDIV_SIGNED_EN
      rb = $urandom;
      sp = longint'($signed(ra)) * longint'($signed(rb));
      do_op($sformatf("mult_rnd%0d", i), 2'b01, ra, rb, sp[63:32], sp[31:0], 1'b0);
      rb = $urandom_range(1, 1000);
      if (i == 1) rb = -rb;
      sq = $signed(ra) / $signed(rb);
      sr = $signed(ra) % $signed(rb);
      do_op($sformatf("div_rnd%0d", i), 2'b11, ra, rb, sr, sq, 1'b0);
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
